// File: rtl/sprite_display_multi.sv
// sprite_display_multi: draws up to NUM_SPRITES instances of one sprite sheet.
// Each instance has its own state in two buffers; the visible buffer changes
// only at frame start (hcount==0 && vcount==0).
// Pixel pipeline: S1 hit/address, S2 sheet ROM read, S3 priority + palette.
// Sheet contents come from rom_pattern(): diagonal stripes of indices
// 1,2,3,0 that shift by one per frame. MEM_INIT_FILE only names the sheet
// file for builds that load one.
// Optional macro SPRITE_ANIM_EN: per-sprite frame animation (type 101 sets
// the period in frames; the frame offset advances every `period` frame starts).
module sprite_display_multi #(
    parameter logic [5:0]  COMPONENT_ID    = 6'b001010,
    parameter int          NUM_SPRITES     = 4,
    parameter int          NUM_FRAMES      = 4,
    parameter int          SPRITE_W        = 64,
    parameter int          SPRITE_H        = 64,
    parameter int          IDX_W           = 4,
    parameter int          TRANSPARENT_IDX = 0,
    parameter logic [23:0] BG_COLOR        = 24'h202020,
    parameter              MEM_INIT_FILE   = "sprite.txt"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] RGB_output
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int AW = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);

    logic w_unused_file;
    assign w_unused_file = ^MEM_INIT_FILE;

    // Command word fields
    logic [5:0]  w_comp;
    logic [4:0]  w_child;
    logic [3:0]  w_action;
    logic [2:0]  w_type;
    logic        w_buf;
    logic [12:0] w_data;
    assign {w_comp, w_child, w_action, w_type, w_buf, w_data} = writedata;

    logic w_cmd, w_set, w_clr, w_commit, w_frame_start, w_frame_ok;
    assign w_cmd         = (w_comp == COMPONENT_ID) && (32'(w_child) < NUM_SPRITES);
    assign w_set         = w_cmd && (w_action == 4'h1);
    assign w_clr         = w_cmd && (w_action == 4'hE);
    assign w_commit      = w_cmd && (w_action == 4'hF);
    assign w_frame_start = (hcount == 10'd0) && (vcount == 10'd0);
    assign w_frame_ok    = 32'(w_data[3:0]) < NUM_FRAMES;

    // Double-buffered per-sprite state, indexed [buffer][child]
    logic          r_vis   [2][NUM_SPRITES];
    logic          r_fh    [2][NUM_SPRITES];
    logic          r_fv    [2][NUM_SPRITES];
    logic [9:0]    r_x     [2][NUM_SPRITES];
    logic [9:0]    r_y     [2][NUM_SPRITES];
    logic [FW-1:0] r_frame [2][NUM_SPRITES];
    logic          r_active, r_pending, r_pending_sel;

    // Apply attribute writes and whole-buffer visibility clears
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_vis[b][i]   <= 1'b0;
                    r_fh[b][i]    <= 1'b0;
                    r_fv[b][i]    <= 1'b0;
                    r_x[b][i]     <= 10'd0;
                    r_y[b][i]     <= 10'd0;
                    r_frame[b][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_clr)
                    r_vis[w_buf][i] <= 1'b0;
                if (w_set && (32'(w_child) == i)) begin
                    case (w_type)
                        3'b001: begin
                            r_vis[w_buf][i] <= w_data[12];
                            r_fh[w_buf][i]  <= w_data[11];
                            r_fv[w_buf][i]  <= w_data[10];
                        end
                        3'b010: r_x[w_buf][i] <= w_data[9:0];
                        3'b011: r_y[w_buf][i] <= w_data[9:0];
                        3'b100: if (w_frame_ok) r_frame[w_buf][i] <= w_data[FW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Commit bookkeeping; a commit seen at frame start swaps on that same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_active      <= 1'b0;
            r_pending     <= 1'b0;
            r_pending_sel <= 1'b0;
        end else if (w_frame_start && (r_pending || w_commit)) begin
            r_active  <= w_commit ? w_buf : r_pending_sel;
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_pending     <= 1'b1;
            r_pending_sel <= w_buf;
        end
    end

    logic [FW-1:0] w_eff_frame [NUM_SPRITES];

`ifdef SPRITE_ANIM_EN
    logic [7:0]    r_period [NUM_SPRITES];
    logic [7:0]    r_cnt    [NUM_SPRITES];
    logic [FW-1:0] r_ofs    [NUM_SPRITES];

    // Frame-rate animation counters; shared by both buffers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_period[i] <= 8'd0;
                r_cnt[i]    <= 8'd0;
                r_ofs[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_set && (w_type == 3'b101) && (32'(w_child) == i)) begin
                    r_period[i] <= w_data[7:0];
                    r_cnt[i]    <= 8'd0;
                    r_ofs[i]    <= '0;
                end else if (w_frame_start && (r_period[i] != 8'd0)) begin
                    if (r_cnt[i] == r_period[i] - 8'd1) begin
                        r_cnt[i] <= 8'd0;
                        r_ofs[i] <= FW'((32'(r_ofs[i]) + 32'd1) % NUM_FRAMES);
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_eff
        assign w_eff_frame[g] = FW'((32'(r_frame[r_active][g]) + 32'(r_ofs[g])) % NUM_FRAMES);
    end
`else
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_eff
        assign w_eff_frame[g] = r_frame[r_active][g];
    end
`endif

    // S1 combinational hit test and sheet address, compared at 11 bits
    logic          w_hit  [NUM_SPRITES];
    logic [AW-1:0] w_addr [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_s1
        logic [10:0] w_h11, w_v11, w_x11, w_y11;
        logic [31:0] w_col, w_row, w_colf, w_rowf;
        assign w_h11  = {1'b0, hcount};
        assign w_v11  = {1'b0, vcount};
        assign w_x11  = {1'b0, r_x[r_active][g]};
        assign w_y11  = {1'b0, r_y[r_active][g]};
        assign w_hit[g] = r_vis[r_active][g]
                        && (w_h11 >= w_x11) && (w_h11 < w_x11 + 11'(SPRITE_W))
                        && (w_v11 >= w_y11) && (w_v11 < w_y11 + 11'(SPRITE_H));
        assign w_col  = 32'(w_h11 - w_x11);
        assign w_row  = 32'(w_v11 - w_y11);
        assign w_colf = r_fh[r_active][g] ? (32'(SPRITE_W - 1) - w_col) : w_col;
        assign w_rowf = r_fv[r_active][g] ? (32'(SPRITE_H - 1) - w_row) : w_row;
        assign w_addr[g] = AW'((32'(w_eff_frame[g]) * 32'(SPRITE_H) + w_rowf) * 32'(SPRITE_W) + w_colf);
    end

    function automatic logic [IDX_W-1:0] rom_pattern(input logic [AW-1:0] a);
        int unsigned ai, col, row, frm;
        ai  = 32'(a);
        col = ai % 32'(SPRITE_W);
        row = (ai / 32'(SPRITE_W)) % 32'(SPRITE_H);
        frm = ai / 32'(SPRITE_W * SPRITE_H);
        return IDX_W'((frm + col + row + 32'd1) % 32'd4);
    endfunction

    function automatic logic [23:0] palette(input logic [IDX_W-1:0] k);
        logic [23:0] c;
        case (32'(k))
            0:       c = 24'hFFCC66;
            1:       c = 24'h33CC33;
            2:       c = 24'hFFFFFF;
            3:       c = 24'h202020;
            4:       c = 24'h202020;
            default: c = BG_COLOR;
        endcase
        return c;
    endfunction

    logic             r_hit1 [NUM_SPRITES];
    logic [AW-1:0]    r_addr [NUM_SPRITES];
    logic             r_hit2 [NUM_SPRITES];
    logic [IDX_W-1:0] r_idx  [NUM_SPRITES];

    // S1 and S2 registers: hit/address, then one ROM read per sprite
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_hit1[i] <= 1'b0;
                r_addr[i] <= '0;
                r_hit2[i] <= 1'b0;
                r_idx[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_hit1[i] <= w_hit[i];
                r_addr[i] <= w_addr[i];
                r_hit2[i] <= r_hit1[i];
                r_idx[i]  <= rom_pattern(r_addr[i]);
            end
        end
    end

    logic             w_any;
    logic [IDX_W-1:0] w_sel_idx;

    // S3 priority: lowest child id with an opaque hit wins
    always_comb begin
        w_any     = 1'b0;
        w_sel_idx = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_hit2[i] && (r_idx[i] != IDX_W'(TRANSPARENT_IDX))) begin
                w_any     = 1'b1;
                w_sel_idx = r_idx[i];
            end
        end
    end

    // S3 output register
    always_ff @(posedge clk) begin
        if (!reset)
            RGB_output <= BG_COLOR;
        else
            RGB_output <= w_any ? palette(w_sel_idx) : BG_COLOR;
    end
endmodule

// File: tb/tb_sprite_display_multi.sv
// Directed bench for sprite_display_multi with the default parameters.
// Sheet index at (frame,row,col) is (frame+row+col+1) mod 4:
// 0 transparent, 1 -> 33CC33, 2 -> FFFFFF, 3 -> 202020.
module tb_sprite_display_multi;
    localparam logic [23:0] BG = 24'h202020;
    localparam logic [23:0] GR = 24'h33CC33;
    localparam logic [23:0] WH = 24'hFFFFFF;
    localparam logic [5:0]  ID = 6'b001010;

    logic        clk;
    logic        reset;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] RGB_output;

    int n_checks;
    int n_errors;

    sprite_display_multi dut (
        .clk        (clk),
        .reset      (reset),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .RGB_output (RGB_output)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [5:0] comp, input int child, input logic [3:0] act,
                        input logic [2:0] typ, input logic b, input logic [12:0] data);
        @(negedge clk);
        writedata = {comp, 5'(child), act, typ, b, data};
        @(negedge clk);
        writedata = 32'd0;
    endtask

    task automatic set_attr(input int child, input logic b, input logic vis,
                            input logic fh, input logic fv);
        send(ID, child, 4'h1, 3'b001, b, {vis, fh, fv, 10'd0});
    endtask

    task automatic set_x(input int child, input logic b, input logic [9:0] x);
        send(ID, child, 4'h1, 3'b010, b, {3'b000, x});
    endtask

    task automatic set_y(input int child, input logic b, input logic [9:0] y);
        send(ID, child, 4'h1, 3'b011, b, {3'b000, y});
    endtask

    task automatic set_frame(input int child, input logic b, input logic [3:0] f);
        send(ID, child, 4'h1, 3'b100, b, {9'd0, f});
    endtask

    task automatic commit(input logic b);
        send(ID, 0, 4'hF, 3'b000, b, 13'd0);
    endtask

    // Present one pixel and compare the colour three clocks later
    task automatic pix(input logic [9:0] h, input logic [9:0] v,
                       input logic [23:0] exp, input string tag);
        @(negedge clk);
        hcount = h;
        vcount = v;
        repeat (3) @(posedge clk);
        #1;
        check(tag, RGB_output, exp);
        hcount = 10'd700;
        vcount = 10'd500;
    endtask

    task automatic frame_start();
        @(negedge clk);
        hcount = 10'd0;
        vcount = 10'd0;
        @(negedge clk);
        hcount = 10'd700;
        vcount = 10'd500;
    endtask

    task automatic frame_start_commit(input logic b);
        @(negedge clk);
        hcount    = 10'd0;
        vcount    = 10'd0;
        writedata = {ID, 5'd0, 4'hF, 3'b000, b, 13'd0};
        @(negedge clk);
        writedata = 32'd0;
        hcount    = 10'd700;
        vcount    = 10'd500;
    endtask

    logic [23:0] anim_exp [5];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        writedata = 32'd0;
        hcount    = 10'd700;
        vcount    = 10'd500;

        // Reset state and BG hold after release
        repeat (3) @(posedge clk);
        #1 check("reset_rgb", RGB_output, BG);
        @(negedge clk);
        reset  = 1'b1;
        hcount = 10'd100;
        vcount = 10'd50;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check("post_reset_hold", RGB_output, BG);
        end

        // Program buf1, commit mid-frame, swap at frame start
        set_attr(0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_x(0, 1'b1, 10'd100);
        set_y(0, 1'b1, 10'd50);
        set_frame(0, 1'b1, 4'd0);
        commit(1'b1);
        pix(100, 50, BG, "pre_swap");
        frame_start();
        pix(100, 50, GR, "post_swap");
        pix(101, 50, WH, "col1");
        pix(99, 50, BG, "left_edge");
        pix(163, 51, GR, "right_in");
        pix(164, 51, BG, "right_out");
        pix(101, 113, GR, "bottom_in");
        pix(101, 114, BG, "bottom_out");
        set_x(0, 1'b1, 10'd200);
        pix(200, 50, GR, "active_write");
        pix(100, 50, BG, "active_write_old");

        // Right-edge sprite must not wrap to column 0
        set_x(0, 1'b1, 10'd1000);
        set_y(0, 1'b1, 10'd20);
        pix(1000, 20, GR, "x1000_col0");
        pix(1001, 20, WH, "x1000_col1");
        pix(5, 20, BG, "no_wrap_5");
        pix(39, 20, BG, "no_wrap_39");
        pix(999, 20, BG, "x1000_left");
        pix(1023, 21, GR, "x1000_last");

        // Overlap priority and transparency
        set_attr(1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_x(1, 1'b1, 10'd300);
        set_y(1, 1'b1, 10'd200);
        set_x(0, 1'b1, 10'd300);
        set_y(0, 1'b1, 10'd200);
        set_frame(0, 1'b1, 4'd3);
        pix(300, 200, GR, "overlap_transp");
        pix(301, 200, GR, "overlap_prio");
        pix(302, 200, WH, "overlap_prio2");

        // Flips
        set_attr(1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_x(0, 1'b1, 10'd0);
        set_y(0, 1'b1, 10'd10);
        set_frame(0, 1'b1, 4'd0);
        set_attr(0, 1'b1, 1'b1, 1'b1, 1'b0);
        pix(0, 10, BG, "flip_h_col63");
        pix(2, 10, WH, "flip_h_col61");
        pix(3, 10, GR, "flip_h_col60");
        set_attr(0, 1'b1, 1'b1, 1'b0, 1'b1);
        pix(1, 10, GR, "flip_v_row63");
        pix(1, 73, WH, "flip_v_row0");

        // Commit override, same-edge commit, clear, no spurious swap
        set_attr(0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_x(0, 1'b0, 10'd400);
        set_y(0, 1'b0, 10'd300);
        commit(1'b1);
        commit(1'b0);
        frame_start();
        pix(400, 300, GR, "override_buf0");
        pix(1, 10, BG, "override_not_buf1");
        frame_start_commit(1'b1);
        pix(1, 10, GR, "same_edge_buf1");
        pix(400, 300, BG, "same_edge_not_buf0");
        commit(1'b0);
        frame_start();
        pix(400, 300, GR, "back_to_buf0");
        send(ID, 0, 4'hE, 3'b000, 1'b0, 13'd0);
        pix(400, 300, BG, "clear_buf0");
        frame_start();
        pix(1, 10, BG, "no_pending_no_swap");
        commit(1'b1);
        frame_start();
        pix(1, 10, GR, "clear_kept_buf1");

        // Animation / frame-range check on buf1 child0
        set_x(0, 1'b1, 10'd500);
        set_y(0, 1'b1, 10'd400);
        set_frame(0, 1'b1, 4'd3);
        set_frame(0, 1'b1, 4'd4);
        set_attr(0, 1'b1, 1'b1, 1'b0, 1'b0);
        send(ID, 0, 4'h1, 3'b101, 1'b1, 13'd2);
`ifdef SPRITE_ANIM_EN
        anim_exp = '{GR, GR, WH, WH, BG};
`else
        anim_exp = '{GR, GR, GR, GR, GR};
`endif
        for (int k = 0; k < 5; k++) begin
            if (k > 0) frame_start();
            pix(501, 400, anim_exp[k], $sformatf("anim_frame%0d", k));
        end

        // Reset with a visible sprite
        @(negedge clk);
        reset  = 1'b0;
        hcount = 10'd501;
        vcount = 10'd400;
        repeat (2) begin
            @(posedge clk);
            #1 check("in_reset_visible", RGB_output, BG);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check("reset_cleared", RGB_output, BG);
        end

        // Ignored commands, then a valid one
        send(ID, 4, 4'h1, 3'b001, 1'b0, {3'b100, 10'd0});
        pix(0, 1, BG, "child_oob");
        send(6'b001011, 0, 4'h1, 3'b001, 1'b0, {3'b100, 10'd0});
        pix(0, 1, BG, "bad_comp");
        set_attr(0, 1'b0, 1'b1, 1'b0, 1'b0);
        pix(0, 1, WH, "valid_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
